// File: rtl/round_controller.sv
// Wordle round sequencer: draws a target from the word ROM, then accepts and
// scores up to MAX_GUESSES guesses with duplicate-letter aware colouring.
module round_controller #(
  parameter int NUM_WORDS   = 100,
  parameter int MAX_GUESSES = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  output logic [6:0]  rom_index,
  input  logic [24:0] rom_word,
  input  logic        guess_valid,
  input  logic [24:0] guess_word,
  output logic        guess_ready,
  output logic        result_valid,
  output logic [9:0]  result,
  output logic [2:0]  guess_count,
  output logic        game_won,
  output logic        game_lost
);

  typedef enum logic [2:0] {
    IDLE, LOAD, PLAY, GREEN, YELLOW, REPORT, WON, LOST
  } state_t;

  state_t          state;
  logic [6:0]      seed;
  logic [4:0][4:0] target;
  logic [4:0][4:0] guess;
  logic [4:0]      green;
  logic [4:0]      yellow;
  logic [4:0]      used;
  logic [2:0]      idx;

  logic [4:0]      green_now;
  logic            hit;
  logic [4:0]      yellow_next;
  logic [4:0]      used_next;

  function automatic logic [9:0] pack_score(input logic [4:0] g, input logic [4:0] y);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      if (g[i])      r[2*i +: 2] = 2'b10;
      else if (y[i]) r[2*i +: 2] = 2'b01;
    end
    return r;
  endfunction

  // Free-running index source; the round picks whatever value it holds
  // in the cycle new_game arrives.
  always_ff @(posedge clk) begin
    if (rst)                             seed <= '0;
    else if (seed == 7'(NUM_WORDS - 1))  seed <= '0;
    else                                 seed <= seed + 7'd1;
  end

  // Lowest still-unused target position holding guess letter idx.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment; a path that leaves one unassigned would infer a latch.
  always_comb begin
    hit         = 1'b0;
    yellow_next = yellow;
    used_next   = used;
    for (int i = 0; i < 5; i++) green_now[i] = (guess[i] == target[i]);
    for (int j = 4; j >= 0; j--) begin
      if (!hit || 1'b1) begin
        if (!used[j] && (target[j] == guess[idx]) && !green[idx]) begin
          hit = 1'b1;
        end
      end
    end
    if (hit) begin
      yellow_next[idx] = 1'b1;
      for (int j = 4; j >= 0; j--) begin
        if (!used[j] && (target[j] == guess[idx])) begin
          used_next = used;
          used_next[j] = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rom_index    <= '0;
      target       <= '0;
      guess        <= '0;
      green        <= '0;
      yellow       <= '0;
      used         <= '0;
      idx          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      guess_ready  <= 1'b0;
      guess_count  <= '0;
      game_won     <= 1'b0;
      game_lost    <= 1'b0;
    end else if (new_game) begin
      state        <= LOAD;
      rom_index    <= seed;
      green        <= '0;
      yellow       <= '0;
      used         <= '0;
      idx          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      guess_ready  <= 1'b0;
      guess_count  <= '0;
      game_won     <= 1'b0;
      game_lost    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: ;
        LOAD: begin
          target      <= rom_word;
          guess_ready <= 1'b1;
          state       <= PLAY;
        end
        PLAY: begin
          if (guess_valid) begin
            guess       <= guess_word;
            guess_ready <= 1'b0;
            state       <= GREEN;
          end
        end
        GREEN: begin
          green  <= green_now;
          used   <= green_now;
          yellow <= '0;
          idx    <= '0;
          state  <= YELLOW;
        end
        YELLOW: begin
          yellow <= yellow_next;
          used   <= used_next;
          if (idx == 3'd4) begin
            result       <= pack_score(green, yellow_next);
            result_valid <= 1'b1;
            guess_count  <= guess_count + 3'd1;
            state        <= REPORT;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        REPORT: begin
          if (&green) begin
            game_won <= 1'b1;
            state    <= WON;
          end else if (guess_count == 3'(MAX_GUESSES)) begin
            game_lost <= 1'b1;
            state     <= LOST;
          end else begin
            guess_ready <= 1'b1;
            state       <= PLAY;
          end
        end
        WON, LOST: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller: directed Wordle cases plus
// randomized games scored by a letter-count reference model.
module tb_round_controller;

  localparam int NUM_WORDS   = 100;
  localparam int MAX_GUESSES = 6;

  logic        clk;
  logic        rst;
  logic        new_game;
  logic [6:0]  rom_index;
  logic [24:0] rom_word;
  logic        guess_valid;
  logic [24:0] guess_word;
  logic        guess_ready;
  logic        result_valid;
  logic [9:0]  result;
  logic [2:0]  guess_count;
  logic        game_won;
  logic        game_lost;

  logic [24:0] rom [NUM_WORDS];
  assign rom_word = rom[rom_index];

  round_controller #(.NUM_WORDS(NUM_WORDS), .MAX_GUESSES(MAX_GUESSES)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .rom_index(rom_index),
    .rom_word(rom_word), .guess_valid(guess_valid), .guess_word(guess_word),
    .guess_ready(guess_ready), .result_valid(result_valid), .result(result),
    .guess_count(guess_count), .game_won(game_won), .game_lost(game_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [24:0] target_m;
  int          exp_count;
  bit          m_won, m_lost;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycles since reset release; the seed is this count modulo NUM_WORDS.
  task automatic tick();
    @(posedge clk);
    if (rst) cyc = 0;
    else     cyc++;
    #1;
  endtask

  function automatic logic [24:0] word5(input string s);
    logic [24:0] w;
    w = '0;
    for (int i = 0; i < 5; i++) w[5*i +: 5] = 5'(s[i] - 8'd97);
    return w;
  endfunction

  // Greens first, then each remaining target letter can colour at most one
  // non-green guess position yellow, leftmost first.
  function automatic logic [9:0] score(input logic [24:0] t, input logic [24:0] g);
    int         cnt [32];
    logic [9:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) cnt[k] = 0;
    for (int i = 0; i < 5; i++) begin
      if (t[5*i +: 5] == g[5*i +: 5]) r[2*i +: 2] = 2'b10;
      else cnt[t[5*i +: 5]]++;
    end
    for (int i = 0; i < 5; i++) begin
      if (r[2*i +: 2] != 2'b10 && cnt[g[5*i +: 5]] > 0) begin
        r[2*i +: 2] = 2'b01;
        cnt[g[5*i +: 5]]--;
      end
    end
    return r;
  endfunction

  function automatic logic [24:0] rand_guess(input logic [24:0] t);
    logic [24:0] w;
    int          p;
    for (int i = 0; i < 5; i++) begin
      p = $urandom_range(0, 4);
      case ($urandom_range(0, 2))
        0:       w[5*i +: 5] = t[5*p +: 5];
        1:       w[5*i +: 5] = 5'($urandom_range(0, 31));
        default: w[5*i +: 5] = t[5*i +: 5];
      endcase
    end
    return w;
  endfunction

  task automatic apply_reset();
    rst = 1'b1; new_game = 1'b0; guess_valid = 1'b0; guess_word = '0;
    tick(); tick();
    check("rst_rom_index",    rom_index,    0);
    check("rst_guess_ready",  guess_ready,  0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result",       result,       0);
    check("rst_guess_count",  guess_count,  0);
    check("rst_game_won",     game_won,     0);
    check("rst_game_lost",    game_lost,    0);
    rst = 1'b0;
  endtask

  task automatic start_game();
    int exp_idx;
    exp_idx  = cyc % NUM_WORDS;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check("load_rom_index",   rom_index,   exp_idx);
    check("load_guess_ready", guess_ready, 0);
    check("load_guess_count", guess_count, 0);
    tick();
    check("play_guess_ready", guess_ready, 1);
    target_m  = rom[exp_idx];
    exp_count = 0;
    m_won     = 1'b0;
    m_lost    = 1'b0;
  endtask

  task automatic do_guess(input logic [24:0] w);
    logic [9:0] exp_r;
    bit         early;
    int         k;
    k = 0;
    while (guess_ready !== 1'b1 && k < 20) begin tick(); k++; end
    check("ready_before_guess", guess_ready, 1);
    exp_r       = score(target_m, w);
    guess_valid = 1'b1;
    guess_word  = w;
    tick();
    guess_valid = 1'b0;
    guess_word  = 25'($urandom);
    check("ready_drop", guess_ready, 0);
    early = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (result_valid !== 1'b0) early = 1'b1;
      tick();
    end
    check("no_early_valid", early, 0);
    exp_count++;
    check("result_valid", result_valid, 1);
    check("result",       result,       exp_r);
    check("guess_count",  guess_count,  exp_count);
    tick();
    m_won  = (exp_r == 10'b1010101010);
    m_lost = !m_won && (exp_count == MAX_GUESSES);
    check("valid_pulse", result_valid, 0);
    check("result_held", result,       exp_r);
    check("game_won",    game_won,     m_won);
    check("game_lost",   game_lost,    m_lost);
    check("ready_after", guess_ready,  !m_won && !m_lost);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] w;
    bit          seen;
    rom[0] = word5("match");
    for (int i = 1; i < NUM_WORDS; i++)
      for (int k = 0; k < 5; k++) rom[i][5*k +: 5] = 5'($urandom_range(0, 25));

    apply_reset();

    // Game 1: target "match" drawn from index 0.
    start_game();
    check("target_is_match", {7'd0, target_m}, 32'({7'd0, 25'b0011100010100110000001100}));
    do_guess(word5("hatch"));
    check("hatch_literal", result, 10'b1010101000);
    do_guess(word5("chart"));
    check("chart_literal", result, 10'b0100010101);
    do_guess(word5("match"));
    check("match_literal", result, 10'b1010101010);
    check("won_count", guess_count, 3);
    guess_valid = 1'b1; guess_word = word5("hatch");
    tick(); guess_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin if (result_valid !== 1'b0) seen = 1'b1; tick(); end
    check("won_ignores_guess", seen, 0);
    check("won_hold", game_won, 1);

    // Game 2: six misses lose the round.
    start_game();
    for (int g = 0; g < MAX_GUESSES; g++) begin
      do begin w = rand_guess(target_m); end while (w == target_m);
      do_guess(w);
    end
    check("lost_count", guess_count, 6);
    guess_valid = 1'b1; guess_word = target_m;
    tick(); guess_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin if (result_valid !== 1'b0) seen = 1'b1; tick(); end
    check("lost_ignores_guess", seen, 0);
    check("lost_hold_count", guess_count, 6);
    check("lost_hold", game_lost, 1);

    // Game 3: new_game during YELLOW abandons the score.
    start_game();
    do_guess(rand_guess(target_m));
    guess_valid = 1'b1; guess_word = rand_guess(target_m);
    tick(); guess_valid = 1'b0;
    tick(); tick();
    check("abort_ready_low", guess_ready, 0);
    new_game = 1'b1;
    tick(); new_game = 1'b0;
    check("abort_count_clear",  guess_count,  0);
    check("abort_result_clear", result,       0);
    check("abort_no_valid",     result_valid, 0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin if (result_valid !== 1'b0) seen = 1'b1; tick(); end
    check("abort_never_valid", seen, 0);
    check("abort_then_ready", guess_ready, 1);

    // new_game and guess_valid together: the guess is dropped.
    new_game = 1'b1; guess_valid = 1'b1; guess_word = word5("match");
    tick(); new_game = 1'b0; guess_valid = 1'b0;
    check("tie_ready_low", guess_ready, 0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin if (result_valid !== 1'b0) seen = 1'b1; tick(); end
    check("tie_guess_dropped", seen, 0);
    check("tie_count", guess_count, 0);

    // Randomized games from random seed points.
    for (int g = 0; g < 5; g++) begin
      repeat ($urandom_range(0, 40)) tick();
      start_game();
      while (!m_won && !m_lost) begin
        w = ($urandom_range(0, 4) == 0) ? target_m : rand_guess(target_m);
        do_guess(w);
      end
    end

    // Seed wrap: new_game exactly 100 and 99 cycles after reset release.
    apply_reset();
    repeat (100) tick();
    start_game();
    check("wrap_100", rom_index, 0);
    apply_reset();
    repeat (99) tick();
    start_game();
    check("wrap_99", rom_index, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
